// File: rtl/note_detector.sv
// Square-wave note detector: measures the input half-period in clk cycles and locks onto one of eight note codes.
// Optional macro NOTE_DETECT_MEAS_EN adds the meas_hp/meas_stb measurement outputs.
module note_detector #(
  parameter int CW      = 21,
  parameter int TOL     = 512,
  parameter int MATCH_N = 3,
  parameter int TIMEOUT = 131071,
  parameter int NOM [0:7] = '{95420, 85035, 75758, 71429, 63776, 56819, 50608, 47801}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          tone_in,
  output logic [2:0]    note,
  output logic          valid,
  output logic          note_stb
`ifdef NOTE_DETECT_MEAS_EN
  ,
  output logic [CW-1:0] meas_hp,
  output logic          meas_stb
`endif
);

  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
  localparam logic [2:0]    MN  = 3'(MATCH_N);

  typedef enum logic [1:0] {IDLE = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  state_t        state;
  state_t        next_state;
  logic          sync1;
  logic          sync2;
  logic          prev;
  logic [CW-1:0] hp_cnt;
  logic [2:0]    match_cnt;
  logic [2:0]    cand;
  logic          tone_edge;
  logic          timeout_hit;
  logic [3:0]    cls;
  logic          hit;
  logic [2:0]    hit_code;
  logic          hold_lock;
  logic [2:0]    cand_upd;
  logic [2:0]    match_upd;
  logic          lock_evt;
  logic          valid_d;
  logic          note_stb_d;
  logic [2:0]    note_d;

  // Returns {hit, code}; scanning downward lets the lowest matching code win.
  function automatic logic [3:0] classify(input logic [CW-1:0] m);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      r = (int'(m) >= NOM[i] - TOL && int'(m) <= NOM[i] + TOL) ? {1'b1, 3'(i)} : r;
    end
    return r;
  endfunction

  // Two-flop synchronizer plus previous-sample register for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= tone_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign tone_edge   = sync2 ^ prev;
  assign timeout_hit = !tone_edge && (hp_cnt == TMO);
  assign cls         = classify(hp_cnt);
  assign hit         = cls[3];
  assign hit_code    = cls[2:0];
  assign hold_lock   = hit && (hit_code == note);

  // Candidate and run-length update applied on a measured edge.
  always_comb begin
    cand_upd  = cand;
    match_upd = 3'd0;
    if (hit && (hit_code == cand)) begin
      match_upd = match_cnt + 3'd1;
    end else if (hit) begin
      cand_upd  = hit_code;
      match_upd = 3'd1;
    end else begin
      cand_upd  = cand;
      match_upd = 3'd0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; an edge takes precedence over a same-cycle timeout.
  always_comb begin
    next_state = state;
    if (!en) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          next_state = tone_edge ? MEASURE : IDLE;
        end
        MEASURE: begin
          if (tone_edge) begin
            next_state = (match_upd == MN) ? LOCKED : MEASURE;
          end else begin
            next_state = timeout_hit ? IDLE : MEASURE;
          end
        end
        LOCKED: begin
          if (tone_edge) begin
            next_state = hold_lock ? LOCKED : MEASURE;
          end else begin
            next_state = timeout_hit ? IDLE : LOCKED;
          end
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  // Output decode: next values of the registered outputs.
  always_comb begin
    lock_evt   = (state == MEASURE) && (next_state == LOCKED);
    valid_d    = (next_state == LOCKED);
    note_stb_d = lock_evt;
    note_d     = lock_evt ? cand_upd : note;
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      note     <= 3'd0;
      valid    <= 1'b0;
      note_stb <= 1'b0;
    end else begin
      note     <= note_d;
      valid    <= valid_d;
      note_stb <= note_stb_d;
    end
  end

  // Half-period counter and match tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      hp_cnt    <= '0;
      match_cnt <= 3'd0;
      cand      <= 3'd0;
    end else if (!en) begin
      hp_cnt    <= '0;
      match_cnt <= 3'd0;
    end else begin
      if (tone_edge) begin
        hp_cnt <= CW'(1);
      end else if (hp_cnt != TMO) begin
        hp_cnt <= hp_cnt + CW'(1);
      end else begin
        hp_cnt <= hp_cnt;
      end
      if (next_state == IDLE) begin
        match_cnt <= 3'd0;
      end else if (tone_edge && (state != IDLE) && !((state == LOCKED) && hold_lock)) begin
        match_cnt <= match_upd;
        cand      <= cand_upd;
      end else begin
        match_cnt <= match_cnt;
      end
    end
  end

`ifdef NOTE_DETECT_MEAS_EN
  // Capture of every measured (non-arming) half-period.
  always_ff @(posedge clk) begin
    if (reset) begin
      meas_hp  <= '0;
      meas_stb <= 1'b0;
    end else if (en && tone_edge && (state != IDLE)) begin
      meas_hp  <= hp_cnt;
      meas_stb <= 1'b1;
    end else begin
      meas_stb <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_note_detector.sv
// Scoreboard bench for note_detector with time-scaled note periods; reference model works on lists of half-periods.
module tb_note_detector;
  localparam int CW  = 21;
  localparam int TOL = 3;
  localparam int MN  = 3;
  localparam int TMO = 600;
  localparam int NOM [0:7] = '{477, 425, 379, 357, 319, 284, 253, 239};

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic tone_in;
  logic [2:0] note;
  logic valid;
  logic note_stb;
`ifdef NOTE_DETECT_MEAS_EN
  logic [CW-1:0] meas_hp;
  logic meas_stb;
  int meas_q[$];
`endif

  note_detector #(.CW(CW), .TOL(TOL), .MATCH_N(MN), .TIMEOUT(TMO), .NOM(NOM)) dut (
    .clk(clk), .reset(reset), .en(en), .tone_in(tone_in),
    .note(note), .valid(valid), .note_stb(note_stb)
`ifdef NOTE_DETECT_MEAS_EN
    , .meas_hp(meas_hp), .meas_stb(meas_stb)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int lock; int code; int at; } ev_t;
  ev_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int sq[$];

  // reference model state: armed = a first edge has been seen, run = consecutive equal hits
  int m_armed = 0;
  int m_locked = 0;
  int m_note = 0;
  int m_cand = 0;
  int m_run = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  function automatic int classify(int n);
    for (int c = 0; c < 8; c++)
      if (n >= NOM[c] - TOL && n <= NOM[c] + TOL) return c;
    return -1;
  endfunction

  function automatic void push_ev(int lock, int code, int at);
    ev_t e;
    e.lock = lock; e.code = code; e.at = at;
    exp_q.push_back(e);
  endfunction

  // model one input toggle at cycle t; gap = distance from previous toggle, nxt = distance to the next one
  function automatic void model_edge(int t, int gap, int nxt);
    int h;
    int was_locked;
    if (m_armed == 0) begin
      m_armed = 1;
      m_run = 0;
    end else begin
`ifdef NOTE_DETECT_MEAS_EN
      meas_q.push_back(gap);
`endif
      h = (gap >= TMO) ? -1 : classify(gap);
      was_locked = m_locked;
      if (!(m_locked == 1 && h == m_note)) begin
        if (m_locked == 1) begin
          push_ev(0, 0, t + 3);
          m_locked = 0;
        end
        if (h < 0) m_run = 0;
        else if (m_run > 0 && h == m_cand) m_run++;
        else begin m_cand = h; m_run = 1; end
        if (was_locked == 0 && m_run == MN) begin
          m_locked = 1;
          m_note = m_cand;
          push_ev(1, m_cand, t + 3);
        end
      end
    end
    if (nxt > TMO) begin
      if (m_locked == 1) push_ev(0, 0, t + 3 + TMO);
      m_locked = 0;
      m_armed = 0;
    end
  endfunction

  task automatic add(input int g, input int n);
    for (int i = 0; i < n; i++) sq.push_back(g);
  endtask

  task automatic run_seq(input int tail);
    int n;
    int prv;
    int nxt;
    n = sq.size();
    @(posedge clk); #1;
    for (int k = 0; k <= n; k++) begin
      prv = (k == 0) ? 0 : sq[k-1];
      nxt = (k < n) ? sq[k] : tail;
      tone_in = ~tone_in;
      model_edge(cyc, prv, nxt);
      repeat (nxt) @(posedge clk);
      #1;
    end
    sq.delete();
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    tone_in = 1'b0;
    if (m_locked == 1) push_ev(0, 0, cyc + 1);
    m_locked = 0; m_armed = 0; m_run = 0; m_note = 0; m_cand = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_note", int'(note), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_stb", int'(note_stb), 0);
  endtask

  task automatic drop_en(input int n);
    @(posedge clk); #1;
    en = 1'b0;
    if (m_locked == 1) push_ev(0, 0, cyc + 1);
    m_locked = 0; m_armed = 0;
    repeat (n) @(posedge clk);
    #1;
    chk("en_off_note_hold", int'(note), m_note);
    chk("en_off_valid", int'(valid), 0);
    en = 1'b1;
  endtask

  // monitor: every strobe or valid fall is matched against the next expected event
  bit mon_on = 1'b0;
  bit valid_prev = 1'b0;
  bit stb_prev = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    if (mon_on) begin
      if (note_stb) begin
        chk("stb_single_cycle", int'(stb_prev), 0);
        chk("stb_with_valid", int'(valid), 1);
        if (exp_q.size() == 0) chk("unexpected_lock", 1, -1);
        else begin
          e = exp_q.pop_front();
          chk("event_kind", 1, e.lock);
          chk("lock_cycle", cyc, e.at);
          chk("lock_note", int'(note), e.code);
        end
      end else if (valid_prev && !valid) begin
        if (exp_q.size() == 0) chk("unexpected_unlock", 0, -1);
        else begin
          e = exp_q.pop_front();
          chk("event_kind", 0, e.lock);
          chk("unlock_cycle", cyc, e.at);
        end
      end else if (!valid_prev && valid) begin
        chk("valid_rise_without_stb", 0, 1);
      end
`ifdef NOTE_DETECT_MEAS_EN
      if (meas_stb) begin
        if (meas_q.size() == 0) chk("unexpected_meas", int'(meas_hp), -1);
        else chk("meas_hp", int'(meas_hp), meas_q.pop_front());
      end
`endif
    end
    valid_prev <= valid;
    stb_prev <= note_stb;
  end

  initial begin
    int c;
    int len;
    int r;
    int g;
    reset = 1'b1; en = 1'b0; tone_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0; en = 1'b1;
    @(negedge clk);
    chk("init_note", int'(note), 0);
    chk("init_valid", int'(valid), 0);
    chk("init_stb", int'(note_stb), 0);
    mon_on = 1'b1;

    add(477, 3); run_seq(TMO + 20);                 // note 0 lock, then silence
    add(242, 3); run_seq(TMO + 20);                 // upper band edge of note 7
    add(243, 9); run_seq(TMO + 20);                 // just outside: never locks
    chk("out_of_band_valid", int'(valid), 0);
    add(319, 3); add(284, 3); run_seq(TMO + 20);    // note 4 then switch to note 5
    add(379, 3); add(180, 1); add(10, 1); add(189, 1); add(379, 3);
    run_seq(TMO + 20);                              // glitch, relock on 2, then timeout
    add(477, 3); run_seq(100);
    pulse_reset();
    add(477, 3); run_seq(TMO + 20);
    add(425, 3); run_seq(50);
    drop_en(20);
    add(425, 3); run_seq(TMO + 20);                 // relock to the same note

    for (int s = 0; s < 4; s++) begin
      c = $urandom_range(0, 7);
      len = $urandom_range(3, 7);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0) c = $urandom_range(0, 7);
        if (r == 1) g = $urandom_range(230, 500);
        else g = NOM[c] + int'($urandom_range(0, 2 * TOL)) - TOL;
        sq.push_back(g);
      end
      run_seq(TMO + 20);
    end

    repeat (10) @(posedge clk);
    chk("events_left", exp_q.size(), 0);
`ifdef NOTE_DETECT_MEAS_EN
    chk("meas_left", meas_q.size(), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
